// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, owner codes
// and the winner-to-owner helper.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  typedef logic [1:0] arb_state_t;

  // Winner one-hot is {ext, cpu}; anything but a lone EXT bit maps to CPU.
  function automatic logic oh_to_owner(input logic [1:0] win_oh);
    return (win_oh == 2'b10) ? OWN_EXT : OWN_CPU;
  endfunction

endpackage

// File: rtl/arb2_sel.sv
// Two-requester winner select. ARB_ROUND_ROBIN_EN selects alternating
// tie-break; the default build gives the CPU fixed priority.
module arb2_sel
  import mem_arb_pkg::*;
(
  input  logic       req_cpu,
  input  logic       req_ext,
  input  logic       last_owner,
  output logic [1:0] win_oh
);

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie the side that was not granted last wins.
  always_comb begin
    win_oh = 2'b00;
    if (req_cpu && req_ext) begin
      if (last_owner == OWN_CPU) begin
        win_oh = 2'b10;
      end else begin
        win_oh = 2'b01;
      end
    end else begin
      win_oh = {req_ext, req_cpu};
    end
  end
`else
  logic last_owner_unused_s;
  assign last_owner_unused_s = last_owner;

  // CPU always beats EXT.
  always_comb begin
    win_oh = 2'b00;
    if (req_cpu) begin
      win_oh = 2'b01;
    end else if (req_ext) begin
      win_oh = 2'b10;
    end else begin
      win_oh = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader-debug) arbiter onto one synchronous memory,
// one access per two cycles. ARB_ROUND_ROBIN_EN enables round-robin ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_r;
  arb_state_t        state_nx_s;
  logic              owner_r;
  logic              we_r;
  logic              last_owner_s;
  logic [1:0]        win_oh_s;
  logic              arb_go_s;
  logic              win_ext_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              cpu_gnt_r;
  logic              ext_gnt_r;
  logic              cpu_rvalid_r;
  logic              ext_rvalid_r;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_r;

  // Remember the most recent winner for tie-breaking.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      last_owner_r <= OWN_EXT;
    end else if (arb_go_s) begin
      last_owner_r <= win_ext_s;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end

  assign last_owner_s = last_owner_r;
`else
  assign last_owner_s = OWN_EXT;
`endif

  arb2_sel u_sel (
    .req_cpu    (cpu_req),
    .req_ext    (ext_req),
    .last_owner (last_owner_s),
    .win_oh     (win_oh_s)
  );

  // Arbitration happens only in IDLE and RESP; a request in RESP is a new access.
  always_comb begin
    arb_go_s    = 1'b0;
    win_ext_s   = oh_to_owner(win_oh_s);
    sel_we_s    = cpu_we;
    sel_addr_s  = cpu_addr;
    sel_wdata_s = cpu_wdata;
    state_nx_s  = ST_IDLE;
    if (win_ext_s == OWN_EXT) begin
      sel_we_s    = ext_we;
      sel_addr_s  = ext_addr;
      sel_wdata_s = ext_wdata;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
    case (state_r)
      ST_IDLE, ST_RESP: begin
        arb_go_s   = (win_oh_s != 2'b00);
        state_nx_s = arb_go_s ? ST_ACC : ST_IDLE;
      end
      ST_ACC:  state_nx_s = ST_RESP;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, captured request and registered outputs; reset abandons any access.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_CPU;
      we_r         <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      cpu_gnt_r    <= 1'b0;
      ext_gnt_r    <= 1'b0;
      cpu_rvalid_r <= 1'b0;
      ext_rvalid_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      mem_en_r     <= arb_go_s;
      mem_we_r     <= arb_go_s & sel_we_s;
      mem_addr_r   <= arb_go_s ? sel_addr_s : {ADDR_W{1'b0}};
      mem_wdata_r  <= arb_go_s ? sel_wdata_s : {DATA_W{1'b0}};
      cpu_gnt_r    <= arb_go_s & (win_ext_s == OWN_CPU);
      ext_gnt_r    <= arb_go_s & (win_ext_s == OWN_EXT);
      cpu_rvalid_r <= (state_r == ST_ACC) & ~we_r & (owner_r == OWN_CPU);
      ext_rvalid_r <= (state_r == ST_ACC) & ~we_r & (owner_r == OWN_EXT);
      if (arb_go_s) begin
        owner_r <= win_ext_s;
        we_r    <= sel_we_s;
      end else begin
        owner_r <= owner_r;
        we_r    <= we_r;
      end
    end
  end

  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign cpu_gnt    = cpu_gnt_r;
  assign ext_gnt    = ext_gnt_r;
  assign cpu_rvalid = cpu_rvalid_r;
  assign ext_rvalid = ext_rvalid_r;
  // Read data arrives straight from the memory in RESP, gated to the owner.
  assign cpu_rdata  = cpu_rvalid_r ? mem_rdata : {DATA_W{1'b0}};
  assign ext_rdata  = ext_rvalid_r ? mem_rdata : {DATA_W{1'b0}};
  assign cpu_wait   = cpu_req & ~(cpu_rvalid_r | (cpu_gnt_r & cpu_we));

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
REQ-002 SHALL have ports, one per line:
- CLK  in  1  clock.
- Reset  in  1  synchronous, active-high reset, sampled on rising CLK.
- cpu_req  in  1  CPU access request (driven from Control MemR/MemW).
- cpu_we  in  1  CPU write when 1.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access issued this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_wait  out  1  CPU stall to the Control FSM.
- ext_req, ext_we, ext_addr, ext_wdata, ext_gnt, ext_rvalid, ext_rdata  SHALL mirror the cpu_* ports, for the loader/debug port.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous memory read data, valid 1 cycle after mem_en.

Function
REQ-003 SHALL implement the FSM IDLE -> ACC -> RESP.
REQ-004 IDLE: if any req=1, SHALL arbitrate, register the winner's we/addr/wdata and owner, and go to ACC next cycle; otherwise stay in IDLE.
REQ-005 ACC (exactly 1 cycle): SHALL drive mem_en=1, mem_we/mem_addr/mem_wdata from the registered values, and assert the owner's gnt for this cycle only, then go to RESP.
REQ-006 RESP (exactly 1 cycle), owner's access a read: SHALL assert the owner's rvalid=1 with rdata=mem_rdata.
REQ-007 RESP, owner's access a write: rvalid SHALL stay 0.
REQ-008 RESP exit: SHALL arbitrate as in IDLE and go directly to ACC if any req=1, else to IDLE.
REQ-009 Requester SHALL hold req, we, addr and wdata stable until it sees gnt.
REQ-010 A req=1 sampled in RESP or IDLE SHALL be treated as a new access.
REQ-011 Latency: req rising in IDLE at cycle N gives gnt at N+1 and rvalid at N+2.
REQ-012 Back-to-back throughput: one access per 2 cycles.
REQ-013 Outside ACC: mem_en=0 and mem_we=0.
REQ-014 Outside RESP, or when not the owner: rvalid=0 and rdata=0.
REQ-015 cpu_wait SHALL equal cpu_req AND NOT (cpu_rvalid OR (cpu_gnt AND cpu_we)); ext side has no wait output.
REQ-016 Loser of arbitration SHALL remain pending and never be dropped.
REQ-017 Simultaneous requests SHALL be resolved per REQ-021/REQ-022.

Reset
REQ-018 Reset=1 SHALL force, on the next rising edge: state=IDLE, all outputs 0, owner=CPU, last-granted pointer=EXT.
REQ-019 Reset asserted during ACC or RESP SHALL abandon the access: no gnt or rvalid after the reset edge, and mem_en=0 from the next cycle.
REQ-020 Requests held through reset SHALL be arbitrated in the first IDLE cycle after Reset deasserts.

Configuration
REQ-021 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, SHALL grant the requester that was not granted last; the pointer updates on every grant.
REQ-022 Without ARB_ROUND_ROBIN_EN: fixed priority, CPU always wins; the pointer logic SHALL be absent.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the state encoding (IDLE=0, ACC=1, RESP=2, 2-bit) and the owner encoding (CPU=0, EXT=1).
REQ-024 Winner selection SHALL live in sub-module arb2_sel (inputs: two requests and the pointer; output: winner one-hot), with the `ifdef applied inside it.

Verification
REQ-025 CPU read, addr=0x0010, memory holds 0x1234, req at cycle 1:
- required: cpu_gnt at cycle 2, mem_en=1, mem_addr=0x0010.
- required: cpu_rvalid=1 with cpu_rdata=0x1234 at cycle 3.
- required: cpu_wait=1 for cycles 1-2 and 0 at cycle 3.
REQ-026 EXT write of 0xBEEF to 0x0020:
- required: ext_gnt, mem_we=1, mem_wdata=0xBEEF for exactly 1 cycle; ext_rvalid never asserted.
- required: a following CPU read of 0x0020 returns 0xBEEF.
REQ-027 Both requesters held continuously, ARB_ROUND_ROBIN_EN defined:
- required: grant order CPU, EXT, CPU, EXT; one gnt every 2 cycles.
REQ-028 Both requesters held continuously, macro undefined:
- required: every grant goes to CPU while cpu_req=1.
- required: EXT is granted in the first arbitration after cpu_req drops.
REQ-029 Reset asserted in the ACC cycle of a CPU read:
- required: no cpu_rvalid; all outputs 0 the next cycle.
- required: a held cpu_req is granted 1 cycle after Reset deasserts.
